// File: rtl/instr_fetch.sv
// Instruction fetch: PC plus memory req/ack, opcode (+ optional immediate) capture, valid/ready hand-off to the uPC.
// Latency: 1 cycle (one-byte) or 2 cycles (two-byte) after F_OP entry with zero-wait memory. Backpressure: HOLD stalls until ins_ready.
// Optional build macro IFETCH_TIMEOUT_EN adds a sticky mem_ack timeout fault.
module instr_fetch #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    input  logic              pc_ld,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        ir,
    output logic [7:0]        opr,
    output logic [7:0]        uaddr,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic              fault
);

    typedef enum logic [1:0] {IDLE, F_OP, F_IMM, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [7:0]        opr_q, opr_d;
    logic              halted;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             expire;

    assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign halted = fault_q;
    assign fault  = fault_q;
`else
    assign halted = 1'b0;
    assign fault  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        opr_d   = opr_q;
`ifdef IFETCH_TIMEOUT_EN
        cnt_d   = '0;
        fault_d = fault_q;
`endif
        case (state_q)
            IDLE: begin
                if (run && !halted) state_d = F_OP;
            end
            F_OP: begin
                if (mem_ack) begin
                    ir_d = mem_data;
                    pc_d = pc_q + ADDR_W'(1);
                    if (mem_data[3]) begin
                        state_d = F_IMM;
                    end else begin
                        opr_d   = '0;
                        state_d = HOLD;
                    end
                end
`ifdef IFETCH_TIMEOUT_EN
                else if (expire) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            F_IMM: begin
                if (mem_ack) begin
                    opr_d   = mem_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = HOLD;
                end
`ifdef IFETCH_TIMEOUT_EN
                else if (expire) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            HOLD: begin
                if (ins_ready) state_d = run ? F_OP : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A branch abandons any in-flight fetch or held instruction; ir/opr keep their old values.
        if (pc_ld) begin
            pc_d    = pc_in;
            ir_d    = ir_q;
            opr_d   = opr_q;
            state_d = (run && !halted) ? F_OP : IDLE;
`ifdef IFETCH_TIMEOUT_EN
            cnt_d   = '0;
            fault_d = fault_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            opr_q   <= '0;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q   <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
`endif
        end
    end

    assign pc        = pc_q;
    assign mem_addr  = pc_q;
    assign ir        = ir_q;
    assign opr       = opr_q;
    assign uaddr     = {ir_q[7:4], 4'b0000};
    assign mem_req   = (state_q == F_OP) || (state_q == F_IMM);
    assign ins_valid = (state_q == HOLD);

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage sitting directly upstream of the microprogram sequencer (uPC).
- Holds the program counter and drives a req/ack handshake to program memory.
- Captures the opcode byte into IR and, when required, one immediate operand byte.
- Presents the microprogram entry address plus operand to the sequencer with a valid/ready handshake. This is the source for the sequencer's "load from PC/decode" path.

Parameters:
ADDR_W, 8, width of PC and memory address; PC wraps modulo 2^ADDR_W.
RESET_PC, 0, PC value loaded on reset.
TIMEOUT, 15, cycles to wait for mem_ack before fault; used only with IFETCH_TIMEOUT_EN.

Ports:
clk  in  1  single clock; all state changes on rising edge.
rst  in  1  synchronous, active-low reset; 0 = reset, sampled on clk rising edge.
run  in  1  1 = fetching permitted; 0 = stop after current instruction is handed off.
mem_addr  out  ADDR_W  program memory address; equals pc while mem_req=1.
mem_req  out  1  fetch request; held high until mem_ack.
mem_ack  in  1  memory data valid; may be high in the same cycle as mem_req (zero-wait).
mem_data  in  8  byte from program memory, sampled when mem_req&&mem_ack.
pc_ld  in  1  load pc from pc_in (branch/jump from datapath).
pc_in  in  ADDR_W  branch target.
pc  out  ADDR_W  current program counter.
ir  out  8  instruction register.
opr  out  8  immediate operand; 0 for one-byte instructions.
uaddr  out  8  microprogram entry address = {ir[7:4],4'b0000}.
ins_valid  out  1  ir/opr/uaddr valid for the sequencer.
ins_ready  in  1  sequencer accepts the instruction.
fault  out  1  fetch timeout flag (0 unless IFETCH_TIMEOUT_EN).

Behaviour:
- Reset (rst=0 at an edge): pc=RESET_PC, ir=0, opr=0, state=IDLE, mem_req=0, ins_valid=0, fault=0. Reset overrides everything, including in-flight handshakes.
- States: IDLE, F_OP, F_IMM, HOLD. mem_req=1 exactly in F_OP/F_IMM; ins_valid=1 exactly in HOLD.
- IDLE: with run=1, go to F_OP next edge; with run=0, stay.
- F_OP: at an edge with mem_ack=1, set ir<=mem_data and pc<=pc+1.
  - If mem_data[3]=1 (two-byte opcode), go to F_IMM.
  - Otherwise set opr<=0 and go to HOLD.
- F_IMM: at an edge with mem_ack=1, set opr<=mem_data, pc<=pc+1, and go to HOLD.
- HOLD: ir/opr/uaddr stay stable while ins_valid=1 and ins_ready=0.
  - Transfer occurs at an edge with ins_ready=1.
  - After transfer: go to F_OP if run=1, else IDLE.
- Zero-wait latency: one-byte instruction gives ins_valid 1 cycle after F_OP entry; two-byte gives 2 cycles. Steady state with ins_ready=1: 2 cycles per one-byte instruction.
- run=0 never aborts a handshake: an in-flight fetch completes and reaches HOLD, then the block parks in IDLE after transfer.
- pc_ld has priority in every state:
  - pc<=pc_in and ir/opr unchanged.
  - Any in-flight fetch is abandoned: mem_ack in that same cycle is ignored and pc does not increment.
  - An untransferred HOLD instruction is discarded, even if ins_ready=1 that cycle.
  - Next state is F_OP if run=1, else IDLE.
  - mem_req drops for at least one cycle only when run=0.
- pc wrap: 2^ADDR_W-1 increments to 0, with no flag.
- mem_addr is registered state (=pc); it never changes while mem_req=1 and mem_ack=0.

Optional Feature:
IFETCH_TIMEOUT_EN:
- Defined: a counter resets on entry to F_OP/F_IMM and increments each cycle mem_req=1 and mem_ack=0.
  - When it reaches TIMEOUT, fault<=1 (sticky) and state<=IDLE; pc is not incremented.
  - While fault=1, the block stays in IDLE regardless of run.
  - Only rst=0 clears fault.
- Undefined: no counter; fault tied to 0; the block waits for mem_ack indefinitely.

Test Plan:
- Reset/start: rst=0 two cycles, then rst=1, run=1, mem_ack=1, memory[0]=8'h25, ins_ready=1 -> mem_req rises 1 cycle after reset release; ins_valid 1 cycle later with ir=8'h25, opr=0, uaddr=8'h20, pc=1.
- Two-byte instruction: memory[1]=8'h38, memory[2]=8'hA5 -> ir=8'h38, opr=8'hA5, uaddr=8'h30, pc=3, valid 2 cycles after F_OP entry.
- Backpressure: ins_ready=0 for 5 cycles in HOLD -> ins_valid, ir, opr stay stable, mem_req=0, pc unchanged; raising ins_ready transfers once, then next fetch starts.
- Branch mid-fetch: mem_ack=0 in F_OP at pc=4, then pc_ld=1, pc_in=8'h80 -> pc=8'h80; next request has mem_addr=8'h80; the discarded fetch produces no ins_valid.
- Wrap and stop: pc=8'hFF, one-byte opcode, run dropped during fetch -> pc becomes 0; instruction is still delivered; block then parks in IDLE with mem_req=0.
- Timeout (IFETCH_TIMEOUT_EN): mem_ack held 0 -> fault=1 after 15 waiting cycles, mem_req=0, run ignored; rst=0 clears fault.
